sprite_write_scheduler: RTL and testbench

Queues CPU writes to sprite registers and replays them onto the display controller's register port only during vertical blank. Sprite position and shape changes therefore never tear mid-frame. Sits between the CPU's memory-mapped I/O decode and the display controller's `register_write_i`/`register_index_i`/`register_write_value_i` inputs, and takes `in_vblank_o` from the display controller as its frame reference.

---
 rtl/sprite_write_scheduler.sv | 157 +++++++++++++++
 tb/tb_sprite_write_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_write_scheduler.sv
// sprite_write_scheduler: queues CPU writes to sprite registers and replays
// them onto the display controller register port in arrival order.
// Optional feature macro: SPRITE_WRITE_DEFER_EN
//   defined   - entries are replayed only while in_vblank_i is high, starting
//               on its rising edge; frame_committed_o pulses when the queue
//               empties within a vblank.
//   undefined - the queue drains whenever it is non-empty, in_vblank_i is
//               ignored and frame_committed_o is tied low.
module sprite_write_scheduler #(
    parameter int FIFO_DEPTH  = 8,
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_write_i,
    input  logic [INDEX_WIDTH-1:0]        cpu_index_i,
    input  logic [DATA_WIDTH-1:0]         cpu_value_i,
    output logic                          cpu_ready_o,
    input  logic                          in_vblank_i,
    output logic                          register_write_o,
    output logic [INDEX_WIDTH-1:0]        register_index_o,
    output logic [DATA_WIDTH-1:0]         register_write_value_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o,
    output logic                          overflow_o,
    output logic                          frame_committed_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = INDEX_WIDTH + DATA_WIDTH;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_next;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // A pop in the same cycle frees a slot, so a write while full is accepted then.
    assign push = cpu_write_i && (!full || pop);

    assign pending_o = count_q;

`ifdef SPRITE_WRITE_DEFER_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_next;
    logic   vblank_q;

    // State register and vblank edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_next;
            vblank_q <= in_vblank_i;
        end
    end

    // Next state, pop request and commit pulse; vblank ending beats an empty queue.
    always_comb begin
        state_next        = state_q;
        pop               = 1'b0;
        frame_committed_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_vblank_i && !vblank_q) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_vblank_i) begin
                    state_next = IDLE;
                end else if (empty) begin
                    frame_committed_o = 1'b1;
                    state_next        = HOLD;
                end else begin
                    pop = 1'b1;
                end
            end
            HOLD: begin
                if (!in_vblank_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    logic unused_vblank;

    assign unused_vblank     = in_vblank_i;
    assign pop               = !empty;
    assign frame_committed_o = 1'b0;
`endif

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + (AW + 1)'(1);
            2'b01:   count_next = count_q - (AW + 1)'(1);
            default: count_next = count_q;
        endcase
    end

    // Queue storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cpu_index_i, cpu_value_i};
        end
    end

    // Pointers, occupancy, status flags and registered replay port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q               <= '0;
            rd_ptr_q               <= '0;
            count_q                <= '0;
            cpu_ready_o            <= 1'b0;
            overflow_o             <= 1'b0;
            register_write_o       <= 1'b0;
            register_index_o       <= '0;
            register_write_value_o <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                {register_index_o, register_write_value_o} <= mem[rd_ptr_q];
            end
            if (cpu_write_i && !push) begin
                overflow_o <= 1'b1;
            end
            count_q          <= count_next;
            cpu_ready_o      <= (count_next != FULL_COUNT);
            register_write_o <= pop;
        end
    end

endmodule

// File: tb/tb_sprite_write_scheduler.sv
// Directed self-checking bench for sprite_write_scheduler.
// Exercises whichever build SPRITE_WRITE_DEFER_EN selects.
module tb_sprite_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_write_i;
    logic [11:0] cpu_index_i;
    logic [15:0] cpu_value_i;
    logic        cpu_ready_o;
    logic        in_vblank_i;
    logic        register_write_o;
    logic [11:0] register_index_o;
    logic [15:0] register_write_value_o;
    logic [3:0]  pending_o;
    logic        overflow_o;
    logic        frame_committed_o;

    int n_checks = 0;
    int n_errors = 0;

    sprite_write_scheduler #(
        .FIFO_DEPTH (8),
        .INDEX_WIDTH(12),
        .DATA_WIDTH (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .cpu_write_i           (cpu_write_i),
        .cpu_index_i           (cpu_index_i),
        .cpu_value_i           (cpu_value_i),
        .cpu_ready_o           (cpu_ready_o),
        .in_vblank_i           (in_vblank_i),
        .register_write_o      (register_write_o),
        .register_index_o      (register_index_o),
        .register_write_value_o(register_write_value_o),
        .pending_o             (pending_o),
        .overflow_o            (overflow_o),
        .frame_committed_o     (frame_committed_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] idx, input logic [15:0] val);
        cpu_write_i = 1'b1;
        cpu_index_i = idx;
        cpu_value_i = val;
        step();
        cpu_write_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step();
    endtask

    task automatic chk_strobe(input string tag, input logic [11:0] idx, input logic [15:0] val);
        chk({tag, "_rw"}, register_write_o, 1);
        chk({tag, "_idx"}, register_index_o, idx);
        chk({tag, "_val"}, register_write_value_o, val);
    endtask

    initial begin
        reset       = 1'b1;
        cpu_write_i = 1'b0;
        cpu_index_i = '0;
        cpu_value_i = '0;
        in_vblank_i = 1'b0;
        step();
        chk("rst_rw", register_write_o, 0);
        chk("rst_idx", register_index_o, 0);
        chk("rst_val", register_write_value_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_ovf", overflow_o, 0);
        chk("rst_commit", frame_committed_o, 0);
        chk("rst_ready", cpu_ready_o, 0);
        reset = 1'b0;
        #1;
        chk("rel_ready_early", cpu_ready_o, 0);
        step();
        chk("rel_ready", cpu_ready_o, 1);
        chk("rel_pending", pending_o, 0);

`ifdef SPRITE_WRITE_DEFER_EN
        // Three writes held until vblank, then replayed with a commit.
        push(12'd3, 16'h0010);
        push(12'd7, 16'h0020);
        push(12'd11, 16'h0030);
        chk("d1_pending", pending_o, 3);
        chk("d1_no_rw", register_write_o, 0);
        step();
        chk("d1_still_no_rw", register_write_o, 0);
        in_vblank_i = 1'b1;
        step();
        chk("d1_n1_rw", register_write_o, 0);
        step();
        chk_strobe("d1_s0", 12'd3, 16'h0010);
        chk("d1_s0_commit", frame_committed_o, 0);
        step();
        chk_strobe("d1_s1", 12'd7, 16'h0020);
        step();
        chk_strobe("d1_s2", 12'd11, 16'h0030);
        chk("d1_commit", frame_committed_o, 1);
        chk("d1_pending_end", pending_o, 0);
        step();
        chk("d1_after_rw", register_write_o, 0);
        chk("d1_after_commit", frame_committed_o, 0);
        chk("d1_idx_hold", register_index_o, 11);
        in_vblank_i = 1'b0;
        step();

        // Overflow: ninth write dropped, first eight replayed.
        do_reset();
        for (int i = 0; i < 8; i++) push(12'(i), 16'(16'h0100 + i));
        chk("d2_full_pending", pending_o, 8);
        chk("d2_full_ready", cpu_ready_o, 0);
        chk("d2_full_ovf", overflow_o, 0);
        push(12'd14, 16'hBEEF);
        chk("d2_ovf", overflow_o, 1);
        chk("d2_ovf_pending", pending_o, 8);
        chk("d2_ovf_ready", cpu_ready_o, 0);
        in_vblank_i = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk_strobe($sformatf("d2_s%0d", i), 12'(i), 16'(16'h0100 + i));
            chk($sformatf("d2_commit%0d", i), frame_committed_o, (i == 7) ? 1 : 0);
        end
        step();
        chk("d2_end_rw", register_write_o, 0);
        chk("d2_end_pending", pending_o, 0);
        chk("d2_ovf_sticky", overflow_o, 1);
        in_vblank_i = 1'b0;
        step();

        // Push and pop together while full.
        do_reset();
        for (int i = 0; i < 8; i++) push(12'(i), 16'(16'h0200 + i));
        in_vblank_i = 1'b1;
        step();
        push(12'h03C, 16'hCAFE);
        chk("d4_pending", pending_o, 8);
        chk("d4_ovf", overflow_o, 0);
        chk_strobe("d4_s0", 12'd0, 16'h0200);
        for (int i = 1; i < 8; i++) begin
            step();
            chk_strobe($sformatf("d4_s%0d", i), 12'(i), 16'(16'h0200 + i));
        end
        step();
        chk_strobe("d4_new", 12'h03C, 16'hCAFE);
        chk("d4_commit", frame_committed_o, 1);
        in_vblank_i = 1'b0;
        step();
        chk("d4_end_ovf", overflow_o, 0);

        // Short vblank leaves entries for the next one.
        do_reset();
        for (int i = 0; i < 5; i++) push(12'(20 + i), 16'(16'h0400 + i));
        in_vblank_i = 1'b1;
        step();
        chk("d3_n1_rw", register_write_o, 0);
        step();
        chk_strobe("d3_s0", 12'd20, 16'h0400);
        step();
        chk_strobe("d3_s1", 12'd21, 16'h0401);
        in_vblank_i = 1'b0;
        #1;
        chk("d3_fall_commit", frame_committed_o, 0);
        step();
        chk("d3_gap_rw", register_write_o, 0);
        chk("d3_gap_pending", pending_o, 3);
        chk("d3_gap_commit", frame_committed_o, 0);
        step();
        in_vblank_i = 1'b1;
        step();
        step();
        chk_strobe("d3_s2", 12'd22, 16'h0402);
        step();
        chk_strobe("d3_s3", 12'd23, 16'h0403);
        step();
        chk_strobe("d3_s4", 12'd24, 16'h0404);
        chk("d3_commit", frame_committed_o, 1);
        in_vblank_i = 1'b0;
        step();

        // Asynchronous reset mid-drain discards the queue.
        do_reset();
        for (int i = 0; i < 3; i++) push(12'(30 + i), 16'(16'h0500 + i));
        in_vblank_i = 1'b1;
        step();
        step();
        chk_strobe("d5_s0", 12'd30, 16'h0500);
        #2;
        reset = 1'b1;
        #1;
        chk("d5_rst_rw", register_write_o, 0);
        chk("d5_rst_idx", register_index_o, 0);
        chk("d5_rst_val", register_write_value_o, 0);
        chk("d5_rst_pending", pending_o, 0);
        chk("d5_rst_ready", cpu_ready_o, 0);
        in_vblank_i = 1'b0;
        reset = 1'b0;
        step();
        step();
        chk("d5_idle_rw", register_write_o, 0);
        chk("d5_idle_pending", pending_o, 0);
        in_vblank_i = 1'b1;
        step();
        chk("d5_commit", frame_committed_o, 1);
        chk("d5_commit_rw", register_write_o, 0);
        step();
        chk("d5_commit_off", frame_committed_o, 0);
        chk("d5_no_rw", register_write_o, 0);
        in_vblank_i = 1'b0;
        step();
`else
        // Single write replayed two cycles later with vblank low.
        push(12'd3, 16'h0042);
        chk("u1_pending", pending_o, 1);
        chk("u1_k1_rw", register_write_o, 0);
        step();
        chk_strobe("u1_s", 12'd3, 16'h0042);
        chk("u1_pending0", pending_o, 0);
        chk("u1_commit", frame_committed_o, 0);
        step();
        chk("u1_after_rw", register_write_o, 0);
        chk("u1_idx_hold", register_index_o, 3);
        chk("u1_val_hold", register_write_value_o, 16'h0042);

        // Back-to-back stream across pointer wrap, vblank high.
        in_vblank_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cpu_write_i = (i < 10);
            cpu_index_i = 12'(12'h100 + i);
            cpu_value_i = 16'(16'h5000 + i);
            step();
            if (i == 0 || i == 11) begin
                chk($sformatf("u2_rw%0d", i), register_write_o, 0);
            end else begin
                chk_strobe($sformatf("u2_s%0d", i - 1), 12'(12'h100 + i - 1), 16'(16'h5000 + i - 1));
            end
            chk($sformatf("u2_pending%0d", i), pending_o, (i < 10) ? 1 : 0);
            chk($sformatf("u2_commit%0d", i), frame_committed_o, 0);
            chk($sformatf("u2_ready%0d", i), cpu_ready_o, 1);
        end
        cpu_write_i = 1'b0;
        in_vblank_i = 1'b0;
        step();

        // Asynchronous reset discards a queued entry.
        push(12'd9, 16'hAAAA);
        push(12'd10, 16'hBBBB);
        chk_strobe("u3_s", 12'd9, 16'hAAAA);
        chk("u3_pending", pending_o, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("u3_rst_rw", register_write_o, 0);
        chk("u3_rst_idx", register_index_o, 0);
        chk("u3_rst_val", register_write_value_o, 0);
        chk("u3_rst_pending", pending_o, 0);
        chk("u3_rst_ready", cpu_ready_o, 0);
        reset = 1'b0;
        step();
        chk("u3_rel_rw", register_write_o, 0);
        chk("u3_rel_ready", cpu_ready_o, 1);
        step();
        chk("u3_rel_rw2", register_write_o, 0);
        chk("u3_rel_pending", pending_o, 0);
        chk("u3_ovf", overflow_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
